// File: rtl/router_reg_if.sv
// -----------------------------------------------------------------------------
// router_reg_if
//
// Bundle between the router FSM / packet source (master side) and the router
// datapath register stage (slave side).
//
//   packet_valid     master->slave  source holds header/payload on datain
//   datain           master->slave  packet byte from the source
//   fifo_full        master->slave  FIFO selected for this packet is full
//   detect_add       master->slave  FSM in decode-address
//   lfd_state        master->slave  FSM in load-first-data
//   ld_state         master->slave  FSM in load-data
//   laf_state        master->slave  FSM in load-after-full
//   full_state       master->slave  FSM in fifo-full
//   rst_int_reg      master->slave  FSM in check-parity-error
//   dout             slave->master  byte presented to the FIFO write port
//   parity_done      slave->master  parity byte has been forwarded
//   low_packet_valid slave->master  packet_valid dropped while FIFO was full
//   err              slave->master  parity mismatch for the current packet
//
// Handshake: there is no valid/ready pair on this bundle. The FSM state
// strobes qualify datain on each rising clk edge; dout is a registered copy
// that the FSM writes into the selected FIFO on the following cycle.
// -----------------------------------------------------------------------------
interface router_reg_if #(
   parameter int WIDTH = 8
);
   logic             packet_valid;
   logic [WIDTH-1:0] datain;
   logic             fifo_full;
   logic             detect_add;
   logic             lfd_state;
   logic             ld_state;
   logic             laf_state;
   logic             full_state;
   logic             rst_int_reg;
   logic [WIDTH-1:0] dout;
   logic             parity_done;
   logic             low_packet_valid;
   logic             err;

   modport master (
      output packet_valid, datain, fifo_full,
      output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
      input  dout, parity_done, low_packet_valid, err
   );

   modport slave (
      input  packet_valid, datain, fifo_full,
      input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
      output dout, parity_done, low_packet_valid, err
   );
endinterface

// File: rtl/router_reg.sv
// -----------------------------------------------------------------------------
// router_reg
//
// Datapath register stage of the 1x3 router. Latches the header byte,
// forwards header / payload / parity bytes on dout toward the output FIFOs,
// parks one byte in hold_byte when the selected FIFO fills, and checks the
// running XOR parity of header+payload against the packet's parity byte.
//
// Ports:
//   clk     system clock, all state changes on the rising edge
//   resetn  asynchronous active-low reset
//   bus     router_reg_if.slave, see the interface file for the signal list
//
// Every output is a flop; nothing is combinational from input to output.
// -----------------------------------------------------------------------------
module router_reg #(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         resetn,
   router_reg_if.slave  bus
);

   logic [WIDTH-1:0] header_byte;
   logic [WIDTH-1:0] hold_byte;
   logic [WIDTH-1:0] int_parity;
   logic [WIDTH-1:0] pkt_parity;
   logic [WIDTH-1:0] dout_q;
   logic             parity_done_q;
   logic             low_pkt_valid_q;
   logic             err_q;

   assign bus.dout             = dout_q;
   assign bus.parity_done      = parity_done_q;
   assign bus.low_packet_valid = low_pkt_valid_q;
   assign bus.err              = err_q;

   // Header capture: the source drives the header while the FSM decodes it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         header_byte <= '0;
      end else if (bus.detect_add && bus.packet_valid) begin
         header_byte <= bus.datain;
      end
   end

   // Output byte path. When the FIFO is full during load-data the incoming
   // byte is parked in hold_byte and dout keeps its last value; the parked
   // byte is released in load-after-full.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dout_q    <= '0;
         hold_byte <= '0;
      end else begin
         if (bus.lfd_state) begin
            dout_q <= header_byte;
         end else if (bus.ld_state && !bus.fifo_full) begin
            dout_q <= bus.datain;
         end else if (bus.ld_state && bus.fifo_full) begin
            hold_byte <= bus.datain;
         end else if (bus.laf_state) begin
            dout_q <= hold_byte;
         end
      end
   end

   // Running parity over header and payload. A payload byte diverted into
   // hold_byte is still accumulated here, so it must not be accumulated
   // again when it is released in load-after-full.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         int_parity <= '0;
      end else if (bus.detect_add) begin
         int_parity <= '0;
      end else if (bus.lfd_state) begin
         int_parity <= int_parity ^ header_byte;
      end else if (bus.ld_state && bus.packet_valid && !bus.full_state) begin
         int_parity <= int_parity ^ bus.datain;
      end
   end

   // The parity byte is the one byte carried in load-data with packet_valid
   // low; capture it once, before parity_done marks the packet finished.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pkt_parity <= '0;
      end else if (bus.detect_add) begin
         pkt_parity <= '0;
      end else if (bus.ld_state && !bus.packet_valid && !parity_done_q) begin
         pkt_parity <= bus.datain;
      end
   end

   // Parity byte arrived while the FIFO was full: remember that it is sitting
   // in hold_byte so load-after-full can complete the packet.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         low_pkt_valid_q <= 1'b0;
      end else if (bus.rst_int_reg || bus.detect_add) begin
         low_pkt_valid_q <= 1'b0;
      end else if (bus.ld_state && !bus.packet_valid && bus.fifo_full) begin
         low_pkt_valid_q <= 1'b1;
      end
   end

   // parity_done rises either when the parity byte is forwarded directly, or
   // when load-after-full releases a parked parity byte.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         parity_done_q <= 1'b0;
      end else if (bus.detect_add) begin
         parity_done_q <= 1'b0;
      end else if (bus.ld_state && !bus.fifo_full && !bus.packet_valid) begin
         parity_done_q <= 1'b1;
      end else if (bus.laf_state && low_pkt_valid_q && !parity_done_q) begin
         parity_done_q <= 1'b1;
      end
   end

   // Compare one cycle after parity_done so both parity registers are final;
   // the result stays visible until the next packet's decode-address ends.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         err_q <= 1'b0;
      end else if (bus.detect_add) begin
         err_q <= 1'b0;
      end else if (parity_done_q) begin
         err_q <= (int_parity != pkt_parity);
      end
   end

endmodule

// File: tb/tb_router_reg.sv
// -----------------------------------------------------------------------------
// tb_router_reg
//
// The bench plays the router FSM and packet source. For each packet the
// expected FIFO byte stream (header, payload, parity) and the expected parity
// verdict come from the packet contents alone; back-pressure may delay bytes
// but never reorder them. A monitor at the falling edge pops the byte queue
// whenever the previous cycle was a FIFO write, and pops the status queue
// whenever the driver flags a status check for the current cycle.
// -----------------------------------------------------------------------------
module tb_router_reg;

  localparam int WIDTH  = 8;
  localparam int S_IDLE = 0;
  localparam int S_DA   = 1;
  localparam int S_LFD  = 2;
  localparam int S_LD   = 3;
  localparam int S_LAF  = 4;
  localparam int S_FULL = 5;
  localparam int S_CPE  = 6;

  typedef struct {
    logic       pd;
    logic       lpv;
    logic       err;
    logic       chk_dout;
    logic [7:0] dout;
    logic       chk_hold;
    logic [7:0] hold;
  } stat_t;

  logic clk    = 1'b0;
  logic resetn = 1'b1;

  router_reg_if #(.WIDTH(WIDTH)) bus();

  router_reg #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- state
  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] exp_q[$];
  stat_t            stat_q[$];

  logic       chk_stat  = 1'b0;
  logic       sb_en     = 1'b1;
  logic       pending   = 1'b0;
  logic       have_prev = 1'b0;
  logic       prev_err  = 1'b0;
  logic [7:0] pl [0:15];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- driver
  task automatic step(input int st, input logic pv, input logic [7:0] d, input logic ff);
    @(posedge clk);
    #1;
    chk_stat             = 1'b0;
    bus.detect_add       = (st == S_DA);
    bus.lfd_state        = (st == S_LFD);
    bus.ld_state         = (st == S_LD);
    bus.laf_state        = (st == S_LAF);
    bus.full_state       = (st == S_FULL);
    bus.rst_int_reg      = (st == S_CPE);
    bus.packet_valid     = pv;
    bus.datain           = d;
    bus.fifo_full        = ff;
  endtask

  task automatic expect_stat(input logic pd, input logic lpv, input logic e,
                             input logic cd, input logic [7:0] d,
                             input logic ch, input logic [7:0] h);
    stat_t s;
    s.pd = pd; s.lpv = lpv; s.err = e;
    s.chk_dout = cd; s.dout = d; s.chk_hold = ch; s.hold = h;
    stat_q.push_back(s);
    chk_stat = 1'b1;
  endtask

  // full_at: -1 no back-pressure, 0..len-1 payload index stalled, len = parity byte stalled
  task automatic send_packet(input logic [7:0] hdr, input int len,
                             input logic [7:0] par, input int full_at);
    logic [7:0] x;
    logic [7:0] nb;
    logic       npv;
    logic       e;
    x = hdr;
    for (int i = 0; i < len; i++) x ^= pl[i];
    e = (x != par);

    exp_q.push_back(hdr);
    for (int i = 0; i < len; i++) exp_q.push_back(pl[i]);
    exp_q.push_back(par);

    step(S_DA, 1'b1, hdr, 1'b0);
    if (have_prev) expect_stat(1'b1, 1'b0, prev_err, 1'b0, 8'h00, 1'b0, 8'h00);
    step(S_LFD, 1'b1, pl[0], 1'b0);
    expect_stat(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    for (int i = 0; i < len; i++) begin
      step(S_LD, 1'b1, pl[i], i == full_at);
      if (i == full_at) begin
        npv = (i + 1 < len);
        nb  = npv ? pl[i+1] : par;
        for (int k = 0; k < int'($urandom_range(1, 2)); k++) begin
          step(S_FULL, npv, nb, 1'b1);
          if (k == 0)
            expect_stat(1'b0, 1'b0, 1'b0, 1'b1, (i == 0) ? hdr : pl[i-1], 1'b1, pl[i]);
        end
        step(S_LAF, npv, nb, 1'b0);
      end
    end

    step(S_LD, 1'b0, par, full_at == len);
    if (full_at == len) begin
      step(S_FULL, 1'b0, par, 1'b1);
      expect_stat(1'b0, 1'b1, 1'b0, 1'b1, pl[len-1], 1'b1, par);
      step(S_LAF, 1'b0, par, 1'b0);
      expect_stat(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      step(S_IDLE, 1'b0, 8'h00, 1'b0);
      expect_stat(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      step(S_CPE, 1'b0, 8'h00, 1'b0);
      expect_stat(1'b1, 1'b1, e, 1'b0, 8'h00, 1'b0, 8'h00);
    end else begin
      step(S_IDLE, 1'b0, 8'h00, 1'b0);
      expect_stat(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      step(S_CPE, 1'b0, 8'h00, 1'b0);
      expect_stat(1'b1, 1'b0, e, 1'b0, 8'h00, 1'b0, 8'h00);
    end
    have_prev = 1'b1;
    prev_err  = e;
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    stat_t      s;
    logic [7:0] e;
    if (!resetn || !sb_en) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dout_unexpected: got %h expected no write", bus.dout);
        end else begin
          e = exp_q.pop_front();
          check8("dout", bus.dout, e);
        end
      end
      if (chk_stat) begin
        if (stat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stat_queue: got empty queue expected an entry");
        end else begin
          s = stat_q.pop_front();
          check8("parity_done", {7'd0, bus.parity_done}, {7'd0, s.pd});
          check8("low_packet_valid", {7'd0, bus.low_packet_valid}, {7'd0, s.lpv});
          check8("err", {7'd0, bus.err}, {7'd0, s.err});
          if (s.chk_dout) check8("dout_hold", bus.dout, s.dout);
          if (s.chk_hold) check8("hold_byte", dut.hold_byte, s.hold);
        end
      end
      // A FIFO write happens in the cycle after any of these; dout is then checked.
      pending = bus.lfd_state || (bus.ld_state && !bus.fifo_full) || bus.laf_state;
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    bus.packet_valid = 1'b0;
    bus.datain       = '0;
    bus.fifo_full    = 1'b0;
    bus.detect_add   = 1'b0;
    bus.lfd_state    = 1'b0;
    bus.ld_state     = 1'b0;
    bus.laf_state    = 1'b0;
    bus.full_state   = 1'b0;
    bus.rst_int_reg  = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 resetn = 1'b0;
    #1;
    check8("rst_dout", bus.dout, 8'h00);
    check8("rst_parity_done", {7'd0, bus.parity_done}, 8'h00);
    check8("rst_low_packet_valid", {7'd0, bus.low_packet_valid}, 8'h00);
    check8("rst_err", {7'd0, bus.err}, 8'h00);
    #10 resetn = 1'b1;

    // Good packet.
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_packet(8'h0D, 3, 8'h0D, -1);
    // Corrupt parity.
    send_packet(8'h0D, 3, 8'hFF, -1);
    // FIFO fills while 8'h22 is being loaded.
    send_packet(8'h0D, 3, 8'h0D, 1);
    // FIFO full on the parity byte.
    send_packet(8'h0D, 3, 8'h0D, 3);
    // Back-to-back: corrupt first packet, clean second packet.
    pl[0] = 8'h5A;
    send_packet(8'h06, 1, 8'h00, -1);
    pl[0] = 8'h01; pl[1] = 8'h02;
    send_packet(8'h09, 2, 8'h0A, -1);

    // Reset in the middle of a packet with every output non-zero.
    @(negedge clk);
    #1 sb_en = 1'b0;
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_packet(8'h0D, 3, 8'h08, 3);
    #2 resetn = 1'b0;
    #1;
    check8("mid_rst_dout", bus.dout, 8'h00);
    check8("mid_rst_parity_done", {7'd0, bus.parity_done}, 8'h00);
    check8("mid_rst_low_packet_valid", {7'd0, bus.low_packet_valid}, 8'h00);
    check8("mid_rst_err", {7'd0, bus.err}, 8'h00);
    check8("mid_rst_hold_byte", dut.hold_byte, 8'h00);
    step(S_IDLE, 1'b0, 8'h00, 1'b0);
    #2 resetn = 1'b1;
    exp_q.delete();
    stat_q.delete();
    have_prev = 1'b0;
    sb_en     = 1'b1;

    // Randomized packets.
    for (int n = 0; n < 30; n++) begin
      int         len;
      int         r;
      int         fa;
      logic [7:0] hdr;
      logic [7:0] x;
      logic [7:0] par;
      len = int'($urandom_range(1, 6));
      hdr = {6'(len), 2'($urandom_range(0, 2))};
      x   = hdr;
      for (int i = 0; i < len; i++) begin
        pl[i] = 8'($urandom);
        x ^= pl[i];
      end
      par = ($urandom_range(0, 1) == 1) ? x : (x ^ 8'($urandom_range(1, 255)));
      r   = int'($urandom_range(0, 3));
      if (r == 1)      fa = int'($urandom_range(0, len - 1));
      else if (r == 2) fa = len;
      else             fa = -1;
      if ($urandom_range(0, 2) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 2)); g++) step(S_IDLE, 1'b0, 8'h00, 1'b0);
      end
      send_packet(hdr, len, par, fa);
    end

    for (int g = 0; g < 3; g++) step(S_IDLE, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    check8("dout_queue_left", 8'(exp_q.size()), 8'h00);
    check8("stat_queue_left", 8'(stat_q.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_reg.md
# router_reg

Datapath register stage of the 1x3 router, directly downstream of the router FSM. It latches the header byte, forwards header, payload and parity bytes on `dout` toward the three output FIFOs, and holds one byte when the selected FIFO fills. It also computes running parity and flags a mismatch. It returns `parity_done` and `low_packet_valid` to the FSM, which uses them to leave the load-after-full state.

## Interface
Parameters:
- WIDTH, 8, data byte width. The header byte is `[WIDTH-1:2]` payload length and `[1:0]` destination address.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- packet_valid  input  1  source asserts while header and payload bytes are on `datain`; low on the parity byte.
- datain  input  WIDTH  packet byte from the source.
- fifo_full  input  1  the FIFO selected for this packet is full.
- detect_add  input  1  FSM is in decode-address.
- lfd_state  input  1  FSM is in load-first-data.
- ld_state  input  1  FSM is in load-data.
- laf_state  input  1  FSM is in load-after-full.
- full_state  input  1  FSM is in fifo-full.
- rst_int_reg  input  1  FSM is in check-parity-error.
- dout  output  WIDTH  byte presented to the FIFO write port.
- parity_done  output  1  the parity byte has been forwarded.
- low_packet_valid  output  1  `packet_valid` dropped while the FIFO was full.
- err  output  1  parity mismatch for the current packet.

## Operation
- **Reset:** `resetn` low asynchronously clears `dout`, `parity_done`, `low_packet_valid`, `err`, and the internal registers `header_byte`, `hold_byte`, `int_parity` and `pkt_parity`.
- **Header capture:** when `detect_add && packet_valid`, `header_byte <= datain`.
- **`dout` update**, first match wins:
  - `lfd_state` → `header_byte`.
  - `ld_state && !fifo_full` → `datain`.
  - `ld_state && fifo_full` → `hold_byte <= datain`; `dout` holds.
  - `laf_state` → `hold_byte`.
  - otherwise `dout` holds.
- **Internal parity:**
  - `detect_add` clears `int_parity`.
  - `lfd_state`: `int_parity ^= header_byte`.
  - `ld_state && packet_valid && !full_state`: `int_parity ^= datain`. This includes a byte diverted to `hold_byte`.
  - The parity byte itself is excluded.
- **Packet parity:** `detect_add` clears `pkt_parity`. `ld_state && !packet_valid && !parity_done` captures `pkt_parity <= datain`.
- **`low_packet_valid`:**
  - Set on `ld_state && !packet_valid && fifo_full`.
  - Cleared on `rst_int_reg` or `detect_add`.
  - Otherwise holds.
- **`parity_done`:**
  - Cleared on `detect_add`.
  - Set on `ld_state && !fifo_full && !packet_valid`.
  - Also set on `laf_state && low_packet_valid && !parity_done`.
  - Otherwise holds.
- **`err`:**
  - Cleared on `detect_add`.
  - In any cycle with `parity_done == 1`, `err <= (int_parity != pkt_parity)`.
  - Otherwise holds.
- **Priority:** the FSM state inputs are one-hot by construction. If `detect_add` coincides with any other input, its clears win.
- **Mid-packet reset:** `resetn` low mid-packet discards the packet. The next header re-initialises all state.

## Timing
- Every output is registered; nothing is combinational from input to output.
- Header:
  - `header_byte` is captured at the edge that ends the decode-address cycle.
  - It appears on `dout` one cycle after the lfd_state cycle begins, i.e. at the edge ending lfd_state.
- Payload latency: a byte sampled in an `ld_state` cycle with `!fifo_full` is on `dout` the next cycle.
- Held byte: it appears on `dout` at the edge ending the `laf_state` cycle.
- Parity, no back-pressure:
  - `parity_done` rises at the edge ending the ld_state cycle that carries the parity byte.
  - `err` is valid one edge later, i.e. during check-parity-error, and holds until the next `detect_add`.
- Back-to-back packets: `detect_add` for packet N+1 clears `parity_done` and `err` at the end of that cycle. `err` for packet N is therefore readable through the whole decode-address cycle.

## Test plan
- **Reset:** async `resetn` low mid-cycle → all outputs 0 immediately, without waiting for a `clk` edge.
- **Good packet:** header 8'h0D, payload 8'h11, 8'h22, 8'h33, parity 8'h0D, no full → `dout` sequence 0D, 11, 22, 33, 0D. `parity_done` = 1 after the parity byte; `err` = 0.
- **Corrupt parity:** same packet with parity 8'hFF → `err` = 1 during check-parity-error; cleared by the next `detect_add`.
- **Full mid-payload:**
  - Stimulus: `fifo_full` rises while 8'h22 is in `ld_state`.
  - Required: `dout` holds 8'h11 and `hold_byte` = 8'h22.
  - After full_state and then laf_state, `dout` = 8'h22.
  - Final `err` = 0 with correct parity.
- **Full on parity byte:**
  - Stimulus: `packet_valid` low with `fifo_full` high in `ld_state`.
  - Required: `low_packet_valid` = 1 and `parity_done` stays 0 until `laf_state`, then 1.
  - `rst_int_reg` clears `low_packet_valid`.
- **Back-to-back packets:** header 8'h06 then header 8'h09 → `int_parity`, `parity_done` and `err` re-initialised at the second `detect_add`. The second packet's parity is checked independently.
